contador_modn_cascada: RTL and testbench
========================================

# contador_modn_cascada

Parametrised, cascadable modulo-BASE counter of DIGITS digits. It generalises the single-digit mod-10 counter to any base and digit count, and adds parallel load, optional down-counting, per-digit carry/borrow pulses and a whole-chain wrap pulse. It sits in the timing/event datapath wherever a multi-digit decimal or arbitrary-base tally is needed, for example display counters and event dividers.

## Interface
Parameters:
- BASE, default 10: modulus of every digit, legal range 2..16.
- DIGITS, default 4: number of cascaded digits, legal range 1..8.
- DW, derived localparam, not overridable: clog2(BASE), the bit width of one digit.

Ports:
- clk  in  1: single clock; all state updates on its rising edge.
- rst  in  1: reset, synchronous and active-high.
- incremento  in  1: count-up enable for one step.
- decremento  in  1: count-down enable for one step. Ignored when CONTADOR_DOWN_EN is undefined.
- cargar  in  1: synchronous parallel-load strobe.
- valor_carga  in  DIGITS*DW: load value, digit k at bits [k*DW +: DW].
- q  out  DIGITS*DW: registered count, same packing as valor_carga.
- acarreo  out  DIGITS: registered per-digit carry/borrow pulse.
- contador_fin  out  1: registered whole-chain wrap pulse.
- carga_invalida  out  1: registered pulse flagging an out-of-range load digit.

## Operation
- Reset value of every output is 0: q = all digits 0, acarreo = 0, contador_fin = 0, carga_invalida = 0.
- Priority per edge: rst, then cargar, then the count step.
- Load:
  - Each digit of valor_carga with value ≥ BASE is loaded as 0; all other digits load as given.
  - carga_invalida = 1 if any digit was sanitised.
  - acarreo and contador_fin are 0 on a load cycle.
- Step direction is decoded from {incremento, decremento}:
  - 10: up.
  - 01: down, only with the macro defined.
  - 00 or 11: hold.
- Up step:
  - Digit k advances iff every digit below k equals BASE-1. Digit 0 always advances.
  - An advancing digit equal to BASE-1 becomes 0 and sets acarreo[k]=1; any other advancing digit increments by 1.
- Down step:
  - Digit k advances iff every digit below k equals 0.
  - An advancing digit equal to 0 becomes BASE-1 and sets acarreo[k]=1; any other advancing digit decrements by 1.
- contador_fin = 1 iff all DIGITS digits wrapped in the same step, i.e. acarreo is all ones.
- Pulses: acarreo, contador_fin and carga_invalida are single-cycle. On every edge without the triggering event (including hold cycles) they return to 0. They do not latch until the next step.
- Invariant: no digit of q ever holds a value ≥ BASE.
- The carry-enable chain is combinational lookahead across digits. There is no cycle-per-digit ripple.

## Timing
- Latency: one cycle. An enable sampled at edge N shows its result in q at edge N.
- acarreo, contador_fin and carga_invalida assert in the same cycle as the q value that caused them, and deassert on the next edge.
- Continuous stepping is supported: one step per cycle with no bubbles.
- Reset mid-operation:
  - rst wins over cargar and the count enables in the same cycle.
  - All outputs are 0 the cycle after rst is sampled.
- cargar together with incremento or decremento: the load wins and no step occurs.
- Inputs must be synchronous to clk; no input synchronisation is performed internally.

## Configuration
- Macro CONTADOR_DOWN_EN.
- Defined: decremento is honoured and borrow logic is built; {1,1} holds.
- Undefined:
  - decremento is ignored and no down logic is synthesised.
  - {incremento=1, decremento=x} steps up.
  - The port remains present, so instantiations are identical in both builds.

## Structure
- Shared package contador_pkg holds:
  - the clog2 function;
  - the direction enum DIR_HOLD/DIR_UP/DIR_DOWN;
  - localparams BASE_MIN=2, BASE_MAX=16, DIGITS_MAX=8.
- Elaboration-time check: BASE and DIGITS outside their legal ranges trigger a fatal error.
- One sub-module, contador_digito, parametrised by BASE:
  - inputs: habilitar, dir, cargar, valor;
  - outputs: digit register, wrap pulse, en_fin (digit at terminal value for the current direction), invalido.
- The top level generates DIGITS instances and ANDs the en_fin signals into the lookahead enables.

## Test plan
All scenarios use BASE=10, DIGITS=3; q is written most significant digit first.
- Reset, then incremento held for 1000 cycles:
  - q runs 000→999→000;
  - acarreo[0] pulses every 10th step and acarreo[1] every 100th;
  - contador_fin pulses exactly once, in the cycle q=000.
- cargar with 998, then two increments:
  - q becomes 999, then 000;
  - on the second step acarreo=111 and contador_fin=1 for one cycle;
  - next cycle all pulses are 0.
- cargar with {1,12,3}:
  - q=103;
  - carga_invalida=1 for exactly one cycle;
  - acarreo=000.
- Macro defined: from 000, one decremento gives q=999 with acarreo=111 and contador_fin=1. Macro undefined: same stimulus gives q=000 with no pulses.
- Simultaneous events:
  - incremento=decremento=1 with macro defined: q holds;
  - cargar=1 with incremento=1 and value 500: q=500;
  - rst=1 with cargar=1: q=000 and all pulses 0.
- After reaching q=009, enables held low for 5 cycles:
  - q stays 009;
  - acarreo and contador_fin stay 0 throughout.

Source files
------------

// File: rtl/contador_modn_cascada_pkg.sv
// Shared types and helpers for the cascadable modulo-BASE counter.
package contador_pkg;

  localparam int BASE_MIN   = 2;
  localparam int BASE_MAX   = 16;
  localparam int DIGITS_MAX = 8;

  typedef enum logic [1:0] {
    DIR_HOLD = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_t;

  // Ceiling log2, never less than 1 so a digit always has at least one bit.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/contador_modn_cascada_digito.sv
// One modulo-BASE digit: load with sanitising, step up/down, wrap pulse.
// Down-count logic is only built when CONTADOR_DOWN_EN is defined.
module contador_digito
  import contador_pkg::*;
#(
  parameter  int BASE = 10,
  localparam int DW   = clog2(BASE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          habilitar,
  input  dir_t          dir,
  input  logic          cargar,
  input  logic [DW-1:0] valor,
  output logic [DW-1:0] q,
  output logic          wrap,
  output logic          en_fin,
  output logic          invalido
);

  localparam logic [DW-1:0] LP_MAX  = DW'(BASE - 1);
  localparam logic [DW-1:0] LP_ONE  = DW'(1);
  localparam logic [DW-1:0] LP_ZERO = '0;

  logic [DW-1:0] r_q;
  logic          r_wrap;
  logic          r_inv;
  logic          w_bad;

  assign w_bad = (valor > LP_MAX);

  // Terminal value for the active direction; feeds the lookahead chain.
  always_comb begin
    en_fin = 1'b0;
    case (dir)
      DIR_UP:   en_fin = (r_q == LP_MAX);
`ifdef CONTADOR_DOWN_EN
      DIR_DOWN: en_fin = (r_q == LP_ZERO);
`endif
      default:  en_fin = 1'b0;
    endcase
  end

  // Digit register: reset, then load, then a step when this digit is enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= LP_ZERO;
      r_wrap <= 1'b0;
      r_inv  <= 1'b0;
    end else if (cargar) begin
      r_q    <= w_bad ? LP_ZERO : valor;
      r_wrap <= 1'b0;
      r_inv  <= w_bad;
    end else begin
      r_wrap <= 1'b0;
      r_inv  <= 1'b0;
      if (habilitar && dir == DIR_UP) begin
        r_q    <= en_fin ? LP_ZERO : (r_q + LP_ONE);
        r_wrap <= en_fin;
      end
`ifdef CONTADOR_DOWN_EN
      else if (habilitar && dir == DIR_DOWN) begin
        r_q    <= en_fin ? LP_MAX : (r_q - LP_ONE);
        r_wrap <= en_fin;
      end
`endif
    end
  end

  assign q        = r_q;
  assign wrap     = r_wrap;
  assign invalido = r_inv;

endmodule

// File: rtl/contador_modn_cascada.sv
// Cascadable modulo-BASE counter of DIGITS digits with parallel load,
// per-digit carry/borrow pulses and a whole-chain wrap pulse.
// Optional feature macro: CONTADOR_DOWN_EN (enables decremento / borrow).
module contador_modn_cascada
  import contador_pkg::*;
#(
  parameter  int BASE   = 10,
  parameter  int DIGITS = 4,
  localparam int DW     = clog2(BASE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 incremento,
  input  logic                 decremento,
  input  logic                 cargar,
  input  logic [DIGITS*DW-1:0] valor_carga,
  output logic [DIGITS*DW-1:0] q,
  output logic [DIGITS-1:0]    acarreo,
  output logic                 contador_fin,
  output logic                 carga_invalida
);

  if (BASE < BASE_MIN || BASE > BASE_MAX) begin : g_bad_base
    $fatal(1, "contador_modn_cascada: BASE %0d out of range", BASE);
  end
  if (DIGITS < 1 || DIGITS > DIGITS_MAX) begin : g_bad_digits
    $fatal(1, "contador_modn_cascada: DIGITS %0d out of range", DIGITS);
  end

  dir_t              w_dir;
  logic [DIGITS-1:0] w_en;
  logic [DIGITS-1:0] w_fin;
  logic [DIGITS-1:0] w_inv;
  logic              r_fin;

  // Direction decode; without the down feature {1,x} counts up.
`ifdef CONTADOR_DOWN_EN
  always_comb begin
    w_dir = DIR_HOLD;
    case ({incremento, decremento})
      2'b10:   w_dir = DIR_UP;
      2'b01:   w_dir = DIR_DOWN;
      default: w_dir = DIR_HOLD;
    endcase
  end
`else
  logic w_unused_dec;
  assign w_unused_dec = decremento;

  always_comb begin
    w_dir = DIR_HOLD;
    if (incremento) w_dir = DIR_UP;
  end
`endif

  // Lookahead enables: a digit moves when every lower digit is terminal.
  always_comb begin
    w_en    = '0;
    w_en[0] = 1'b1;
    for (int k = 1; k < DIGITS; k++) begin
      w_en[k] = w_en[k-1] & w_fin[k-1];
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    contador_digito #(.BASE(BASE)) u_dig (
      .clk      (clk),
      .rst      (rst),
      .habilitar(w_en[k]),
      .dir      (w_dir),
      .cargar   (cargar),
      .valor    (valor_carga[k*DW +: DW]),
      .q        (q[k*DW +: DW]),
      .wrap     (acarreo[k]),
      .en_fin   (w_fin[k]),
      .invalido (w_inv[k])
    );
  end

  // Whole-chain wrap: the top digit is enabled and terminal, so all wrap.
  always_ff @(posedge clk) begin
    if (rst || cargar) r_fin <= 1'b0;
    else               r_fin <= w_en[DIGITS-1] & w_fin[DIGITS-1];
  end

  assign contador_fin   = r_fin;
  assign carga_invalida = |w_inv;

endmodule

// File: tb/tb_contador_modn_cascada.sv
// Scoreboard bench for contador_modn_cascada (BASE=10, DIGITS=3).
module tb_contador_modn_cascada;

  localparam int BASE   = 10;
  localparam int DIGITS = 3;
  localparam int DW     = 4;
`ifdef CONTADOR_DOWN_EN
  localparam bit DOWN_EN = 1'b1;
`else
  localparam bit DOWN_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 incremento = 1'b0;
  logic                 decremento = 1'b0;
  logic                 cargar = 1'b0;
  logic [DIGITS*DW-1:0] valor_carga = '0;
  logic [DIGITS*DW-1:0] q;
  logic [DIGITS-1:0]    acarreo;
  logic                 contador_fin;
  logic                 carga_invalida;

  always #5 clk = ~clk;

  contador_modn_cascada #(.BASE(BASE), .DIGITS(DIGITS)) dut (
    .clk           (clk),
    .rst           (rst),
    .incremento    (incremento),
    .decremento    (decremento),
    .cargar        (cargar),
    .valor_carga   (valor_carga),
    .q             (q),
    .acarreo       (acarreo),
    .contador_fin  (contador_fin),
    .carga_invalida(carga_invalida)
  );

  typedef struct {
    logic [11:0] q;
    logic [2:0]  ac;
    logic        fin;
    logic        inv;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   m_val = 0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   n_a0 = 0, n_a1 = 0, n_fin = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] pack(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Reference model: the count is a plain integer 0..999.
  task automatic drive(input bit r, input bit i, input bit d, input bit l,
                       input logic [11:0] v);
    exp_t e;
    int   pw;
    int   sum;
    logic [3:0] dg;
    @(posedge clk);
    #1;
    rst = r; incremento = i; decremento = d; cargar = l; valor_carga = v;
    e.ac = '0; e.fin = 1'b0; e.inv = 1'b0;
    if (r) begin
      m_val = 0;
    end else if (l) begin
      sum = 0; pw = 1;
      for (int k = 0; k < DIGITS; k++) begin
        dg = v[k*DW +: DW];
        if (dg >= 4'(BASE)) begin
          dg = 4'd0;
          e.inv = 1'b1;
        end
        sum = sum + int'(dg) * pw;
        pw = pw * BASE;
      end
      m_val = sum;
    end else if (i && !(d && DOWN_EN)) begin
      pw = 1;
      for (int k = 0; k < DIGITS; k++) begin
        pw = pw * BASE;
        e.ac[k] = ((m_val % pw) == pw - 1);
      end
      m_val = (m_val + 1) % 1000;
    end else if (DOWN_EN && d && !i) begin
      pw = 1;
      for (int k = 0; k < DIGITS; k++) begin
        pw = pw * BASE;
        e.ac[k] = ((m_val % pw) == 0);
      end
      m_val = (m_val + 999) % 1000;
    end
    e.fin = &e.ac;
    e.q   = pack(m_val);
    e.due = cyc + 1;
    sb.push_back(e);
  endtask

  // Monitor: compare every due expectation against the DUT outputs.
  always @(negedge clk) begin
    exp_t e;
    if (acarreo[0] === 1'b1) n_a0++;
    if (acarreo[1] === 1'b1) n_a1++;
    if (contador_fin === 1'b1) n_fin++;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (q !== e.q || acarreo !== e.ac || contador_fin !== e.fin ||
          carga_invalida !== e.inv) begin
        errors++;
        $display("FAIL outputs cyc=%0d: got q=%h ac=%b fin=%b inv=%b, want q=%h ac=%b fin=%b inv=%b",
                 cyc, q, acarreo, contador_fin, carga_invalida, e.q, e.ac, e.fin, e.inv);
      end
    end
  end

  task automatic drain();
    for (int t = 0; t < 20 && sb.size() > 0; t++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations still pending, want 0", sb.size());
    end
  endtask

  task automatic check_cnt(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, '0);
    drive(1, 0, 0, 0, '0);
    drain();

    n_a0 = 0; n_a1 = 0; n_fin = 0;
    for (int n = 0; n < 1000; n++) drive(0, 1, 0, 0, '0);
    drain();
    check_cnt("acarreo0_pulses", n_a0, 100);
    check_cnt("acarreo1_pulses", n_a1, 10);
    check_cnt("fin_pulses", n_fin, 1);

    drive(0, 0, 0, 1, pack(998));
    drive(0, 1, 0, 0, '0);
    drive(0, 1, 0, 0, '0);
    drive(0, 0, 0, 0, '0);
    drive(0, 0, 0, 0, '0);

    drive(0, 0, 0, 1, {4'd1, 4'd12, 4'd3});
    drive(0, 0, 0, 0, '0);

    drive(1, 0, 0, 0, '0);
    drive(0, 0, 1, 0, '0);
    drive(0, 0, 0, 0, '0);

    drive(0, 1, 1, 0, '0);
    drive(0, 1, 0, 1, pack(500));
    drive(1, 0, 0, 1, pack(777));
    drive(0, 0, 0, 0, '0);

    for (int n = 0; n < 9; n++) drive(0, 1, 0, 0, '0);
    for (int n = 0; n < 5; n++) drive(0, 0, 0, 0, '0);
    drain();

    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 99) == 0, 1'($urandom), 1'($urandom),
            $urandom_range(0, 19) == 0, 12'($urandom));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
